// File: rtl/mem_load_ext.sv
// -----------------------------------------------------------------------------
// mem_load_ext
//
// Load-data extension and merge unit sitting between the MEM stage and
// writeback. Load descriptors (type, byte offset, old rt) are queued in a
// 2-entry in-order FIFO. When the memory returns the word for the oldest
// outstanding load, the head descriptor is popped and the raw little-endian
// word is byte/half selected and extended (LB/LBU/LH/LHU), passed through
// (LW) or merged with the old rt value (LWL/LWR). The result lands in a
// single output register one cycle after the beat.
//
// A flush cancels every outstanding load. Memory beats for those loads are
// still coming back, so they are counted in discard_cnt and swallowed as
// they arrive. Outstanding plus discarded loads never exceed two.
//
// Ports
//   clk           in   1   rising-edge clock
//   resetn        in   1   asynchronous active-low reset
//   req_valid     in   1   MEM stage presents a load descriptor
//   req_ready     out  1   descriptor accepted when req_valid && req_ready
//   req_loadtype  in   3   0 LB, 1 LBU, 2 LH, 3 LHU, 4 LW, 5 LWL, 6 LWR
//   req_addr_lo   in   2   byte offset (address bits [1:0])
//   req_rt_old    in   32  old rt value, merged by LWL/LWR
//   rdata_valid   in   1   memory presents the word for the oldest load
//   rdata_ready   out  1   beat accepted when rdata_valid && rdata_ready
//   rdata         in   32  raw little-endian memory word
//   flush         in   1   cancel all outstanding loads
//   wb_valid      out  1   wb_data holds a completed load result
//   wb_ready      in   1   writeback consumes the result
//   wb_data       out  32  extended/merged load result
// -----------------------------------------------------------------------------
module mem_load_ext (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_loadtype,
  input  logic [1:0]  req_addr_lo,
  input  logic [31:0] req_rt_old,
  input  logic        rdata_valid,
  output logic        rdata_ready,
  input  logic [31:0] rdata,
  input  logic        flush,
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic [31:0] wb_data
);

  typedef enum logic [2:0] {
    LT_LB   = 3'd0,
    LT_LBU  = 3'd1,
    LT_LH   = 3'd2,
    LT_LHU  = 3'd3,
    LT_LW   = 3'd4,
    LT_LWL  = 3'd5,
    LT_LWR  = 3'd6,
    LT_RSVD = 3'd7
  } load_type_e;

  typedef struct packed {
    load_type_e  load_type;
    logic [1:0]  addr_lo;
    logic [31:0] rt_old;
  } desc_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  desc_t       fifo_mem [2];
  logic        rd_ptr;
  logic        wr_ptr;
  logic [1:0]  count;        // outstanding (live) loads in the FIFO
  logic [1:0]  discard_cnt;  // beats still owed for flushed loads

  // ---------------------------------------------------------------------------
  // Handshakes
  // ---------------------------------------------------------------------------
  logic [2:0]  occupancy;
  logic [2:0]  flush_discard;
  logic        beat_accept;
  logic        beat_drop;
  logic        pop;
  logic        push;
  desc_t       head;
  desc_t       desc_in;

  assign occupancy = {1'b0, count} + {1'b0, discard_cnt};

  // Live and discarded loads share the same two memory slots.
  assign req_ready = !flush && (occupancy < 3'd2);

  // A discarded beat never needs the output register, so it is always taken.
  // A live beat needs room in the output register this cycle.
  assign rdata_ready = (discard_cnt != 2'd0) ||
                       ((count != 2'd0) && (!wb_valid || wb_ready));

  assign beat_accept = rdata_valid && rdata_ready;
  assign beat_drop   = beat_accept && (discard_cnt != 2'd0);
  assign pop         = beat_accept && (discard_cnt == 2'd0);
  assign push        = req_valid && req_ready;

  assign head    = fifo_mem[rd_ptr];
  assign desc_in = '{load_type: load_type_e'(req_loadtype),
                     addr_lo:   req_addr_lo,
                     rt_old:    req_rt_old};

  // On flush every live load becomes a discard, minus the one whose beat (if
  // any) is being swallowed right now. The invariant occupancy <= 2 keeps
  // the result within two bits.
  assign flush_discard = occupancy - {2'b00, beat_accept};

  // ---------------------------------------------------------------------------
  // Result formation for the head descriptor
  // ---------------------------------------------------------------------------
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] result;

  // NOTE: every variable driven here gets a default up front so that no path
  // through the case statements leaves it unassigned and infers a latch.
  always_comb begin
    byte_sel = rdata[{head.addr_lo, 3'b000} +: 8];
    half_sel = head.addr_lo[1] ? rdata[31:16] : rdata[15:0];
    result   = 32'h0;
    unique case (head.load_type)
      LT_LB:   result = {{24{byte_sel[7]}}, byte_sel};
      LT_LBU:  result = {24'h0, byte_sel};
      LT_LH:   result = {{16{half_sel[15]}}, half_sel};
      LT_LHU:  result = {16'h0, half_sel};
      LT_LW:   result = rdata;
      // LWL fills the high-order bytes of rt from the low-order memory bytes.
      LT_LWL: begin
        unique case (head.addr_lo)
          2'd0: result = {rdata[7:0],  head.rt_old[23:0]};
          2'd1: result = {rdata[15:0], head.rt_old[15:0]};
          2'd2: result = {rdata[23:0], head.rt_old[7:0]};
          2'd3: result = rdata;
        endcase
      end
      // LWR fills the low-order bytes of rt from the high-order memory bytes.
      LT_LWR: begin
        unique case (head.addr_lo)
          2'd0: result = rdata;
          2'd1: result = {head.rt_old[31:24], rdata[31:8]};
          2'd2: result = {head.rt_old[31:16], rdata[31:16]};
          2'd3: result = {head.rt_old[31:8],  rdata[31:24]};
        endcase
      end
      LT_RSVD: result = 32'h0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Descriptor storage
  // ---------------------------------------------------------------------------
  // NOTE: the payload array has no reset. An entry is only read while count
  // says it is live, and count itself is reset, so stale contents are never
  // observed.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= desc_in;
    end
  end

  // ---------------------------------------------------------------------------
  // Control and output register
  // ---------------------------------------------------------------------------
  // NOTE: all state here uses non-blocking assignment so every register sees
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count       <= 2'd0;
      discard_cnt <= 2'd0;
      rd_ptr      <= 1'b0;
      wr_ptr      <= 1'b0;
      wb_valid    <= 1'b0;
      wb_data     <= 32'h0;
    end else if (flush) begin
      // req_ready is low during flush, so no push can coincide with this.
      count       <= 2'd0;
      rd_ptr      <= 1'b0;
      wr_ptr      <= 1'b0;
      wb_valid    <= 1'b0;
      discard_cnt <= flush_discard[1:0];
    end else begin
      if (beat_drop) begin
        discard_cnt <= discard_cnt - 2'd1;
      end

      if (push) begin
        wr_ptr <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end

      unique case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase

      // A pop only happens when the register is empty or being consumed, so
      // a refill overrides the consume and wb_valid stays high.
      if (pop) begin
        wb_valid <= 1'b1;
        wb_data  <= result;
      end else if (wb_ready) begin
        wb_valid <= 1'b0;
      end
    end
  end

endmodule
